// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the integer register-file write side.
package regfile_writeback_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  // Producer identifiers, also used as the round-robin "last winner" record.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MD  = 1'b1;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // One write-back request: a destination and its data, plus a valid flag.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_decoder.sv
// 5-to-32 one-hot decoder with enable; the structural inverse of a read mux.
module decoder_5to32
  import regfile_writeback_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NREGS-1:0]     onehot
);

  // Raise exactly one bit when enabled, none otherwise.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write side of the 32x32 register file: two-producer write-back arbitration
// with a one-entry skid buffer, one-hot register update and busy scoreboard.
//
// Handshake: a producer transfers on a rising edge where valid & ready are both
// 1; ready is a function of internal state only (never of valid), and a
// producer holds rd/data stable while valid=1 and ready=0.
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_rd,
  input  logic [31:0]           alu_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [4:0]            md_rd,
  input  logic [31:0]           md_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic [31:0]           busy,
  output logic [1023:0]         regs_flat
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  wb_req_t          skid_q, skid_d;
  logic             last_win_q, last_win_d;
  logic             rdy_en_q, rdy_en_d;

  wb_req_t          alu_req, md_req, wr;
  logic             ready, alu_fire, md_fire;
  logic [NREGS-1:0] wr_we, issue_set;

  // Both producers see the same ready: open once out of reset, shut while the
  // skid entry is waiting to drain.
  assign ready     = rdy_en_q & ~skid_q.valid;
  assign alu_ready = ready;
  assign md_ready  = ready;
  assign alu_fire  = alu_valid & ready;
  assign md_fire   = md_valid & ready;

  assign alu_req = '{valid: 1'b1, rd: alu_rd, data: alu_data};
  assign md_req  = '{valid: 1'b1, rd: md_rd,  data: md_data};

  // Select the single write for this cycle; the contention loser goes to skid.
  always_comb begin
    wr         = '0;
    skid_d     = '0;
    last_win_d = last_win_q;
    rdy_en_d   = 1'b1;
    if (skid_q.valid) begin
      wr = skid_q;
    end else if (alu_fire && md_fire) begin
      if (last_win_q == SRC_MD) begin
        wr         = alu_req;
        skid_d     = md_req;
        last_win_d = SRC_ALU;
      end else begin
        wr         = md_req;
        skid_d     = alu_req;
        last_win_d = SRC_MD;
      end
    end else if (alu_fire) begin
      wr = alu_req;
    end else if (md_fire) begin
      wr = md_req;
    end
  end

  // x0 is excluded at the decoder enable, so it is never written or marked busy.
  decoder_5to32 u_wr_dec (
    .idx    (wr.rd),
    .en     (wr.valid && (wr.rd != ZERO_REG)),
    .onehot (wr_we)
  );

  decoder_5to32 u_issue_dec (
    .idx    (issue_rd),
    .en     (issue_valid && (issue_rd != ZERO_REG)),
    .onehot (issue_set)
  );

  // Register update and scoreboard; a same-edge issue beats the clear.
  always_comb begin
    busy_d = (busy_q & ~wr_we) | issue_set;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = wr_we[i] ? wr.data : regs_q[i];
    end
  end

  // State register; reset discards any pending skid entry and blocks the write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      skid_q     <= '0;
      last_win_q <= SRC_ALU;
      rdy_en_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      skid_q     <= skid_d;
      last_win_q <= last_win_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  assign busy = busy_q;

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat[XLEN*g +: XLEN] = regs_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference model.
module tb_regfile_writeback;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          alu_valid, md_valid, issue_valid;
  logic          alu_ready, md_ready;
  logic [4:0]    alu_rd, md_rd, issue_rd;
  logic [31:0]   alu_data, md_data;
  logic [31:0]   busy;
  logic [1023:0] regs_flat;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_writeback dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .regs_flat   (regs_flat)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Accepted-but-not-yet-written requests, {rd, data}, oldest first.
  logic [36:0] exp_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  bit          m_open;        // producers may be accepted (out of reset)
  bit          m_md_first;    // md gets priority at the next contention
  bit          m_valid = 0;

  function automatic bit m_ready();
    return m_open && (exp_q.size() == 0);
  endfunction

  task automatic m_commit(input logic [4:0] rd, input logic [31:0] data);
    if (rd != 5'd0) begin
      m_regs[rd] = data;
      m_busy[rd] = 1'b0;
    end
  endtask

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
      exp_q.delete();
      m_open = 0;
      m_md_first = 1;
    end else begin
      logic [36:0] e;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_commit(e[36:32], e[31:0]);
      end else if (m_open) begin
        if (alu_valid && md_valid) begin
          if (m_md_first) begin
            m_commit(md_rd, md_data);
            exp_q.push_back({alu_rd, alu_data});
          end else begin
            m_commit(alu_rd, alu_data);
            exp_q.push_back({md_rd, md_data});
          end
          m_md_first = !m_md_first;
        end else if (alu_valid) begin
          m_commit(alu_rd, alu_data);
        end else if (md_valid) begin
          m_commit(md_rd, md_data);
        end
      end
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      m_open = 1;
    end
    m_valid = 1;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    if (m_valid) begin
      logic [1023:0] m_flat;
      for (int i = 0; i < 32; i++) m_flat[32*i +: 32] = m_regs[i];
      n_cmp++;
      if (alu_ready !== m_ready()) begin
        n_bad++;
        $display("FAIL model_alu_ready t=%0t got=%b want=%b", $time, alu_ready, m_ready());
      end
      n_cmp++;
      if (md_ready !== m_ready()) begin
        n_bad++;
        $display("FAIL model_md_ready t=%0t got=%b want=%b", $time, md_ready, m_ready());
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_bad++;
        $display("FAIL model_busy t=%0t got=%h want=%h", $time, busy, m_busy);
      end
      n_cmp++;
      if (regs_flat !== m_flat) begin
        n_bad++;
        for (int i = 0; i < 32; i++) begin
          if (regs_flat[32*i +: 32] !== m_regs[i])
            $display("FAIL model_x%0d t=%0t got=%h want=%h", i, $time,
                     regs_flat[32*i +: 32], m_regs[i]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    md_valid = 0;  md_rd = '0;  md_data = '0;
    issue_valid = 0; issue_rd = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1; alu_rd = rd; alu_data = data;
  endtask

  task automatic drive_md(input logic [4:0] rd, input logic [31:0] data);
    md_valid = 1; md_rd = rd; md_data = data;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [31:0] xr(input int i);
    return regs_flat[32*i +: 32];
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 0;
    idle_inputs();
    step(2);
    check("reset_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("reset_md_ready",  {31'd0, md_ready},  32'd0);
    check("reset_regs_nonzero", {31'd0, |regs_flat}, 32'd0);
    check("reset_busy", busy, 32'd0);

    reset_n = 1;
    step(1);
    check("post_reset_ready", {30'd0, alu_ready, md_ready}, 32'd3);

    // Single ALU write.
    drive_alu(5'd5, 32'hDEADBEEF);
    step(1);
    idle_inputs();
    check("x5_single", xr(5), 32'hDEADBEEF);
    check("x6_untouched", xr(6), 32'd0);

    // x0 protection.
    drive_md(5'd0, 32'hFFFFFFFF);
    issue_valid = 1; issue_rd = 5'd0;
    step(1);
    idle_inputs();
    check("x0_stays_zero", xr(0), 32'd0);
    check("busy0_stays_zero", {31'd0, busy[0]}, 32'd0);

    // Contention: md wins first, ALU goes to skid.
    drive_alu(5'd3, 32'h11);
    drive_md(5'd4, 32'h22);
    step(1);
    idle_inputs();
    check("cont1_x4", xr(4), 32'h22);
    check("cont1_x3_pending", xr(3), 32'd0);
    check("cont1_readies", {30'd0, alu_ready, md_ready}, 32'd0);
    step(1);
    check("cont2_x3", xr(3), 32'h11);
    check("cont2_readies", {30'd0, alu_ready, md_ready}, 32'd3);

    // Repeat contention: ALU now wins.
    drive_alu(5'd3, 32'h33);
    drive_md(5'd4, 32'h44);
    step(1);
    idle_inputs();
    check("rr_x3_alu_first", xr(3), 32'h33);
    check("rr_x4_old", xr(4), 32'h22);
    step(1);
    check("rr_x4_skid", xr(4), 32'h44);

    // Same rd collision: md wins this round, ALU's value lands last.
    drive_alu(5'd7, 32'hA);
    drive_md(5'd7, 32'hB);
    step(1);
    idle_inputs();
    check("same_rd_first", xr(7), 32'hB);
    step(1);
    check("same_rd_final", xr(7), 32'hA);

    // Scoreboard set / clear / set-wins.
    issue_valid = 1; issue_rd = 5'd9;
    step(1);
    idle_inputs();
    check("busy9_set", {31'd0, busy[9]}, 32'd1);
    drive_alu(5'd9, 32'h99);
    issue_valid = 1; issue_rd = 5'd9;
    step(1);
    idle_inputs();
    check("busy9_set_wins", {31'd0, busy[9]}, 32'd1);
    check("x9_written", xr(9), 32'h99);
    drive_alu(5'd9, 32'h9A);
    step(1);
    idle_inputs();
    check("busy9_cleared", {31'd0, busy[9]}, 32'd0);
    check("x9_rewritten", xr(9), 32'h9A);

    // Reset with a skid entry pending (ALU wins, md rd=13 in skid).
    issue_valid = 1; issue_rd = 5'd13;
    drive_alu(5'd12, 32'h12);
    drive_md(5'd13, 32'h13);
    step(1);
    idle_inputs();
    check("pre_reset_x12", xr(12), 32'h12);
    check("pre_reset_busy13", {31'd0, busy[13]}, 32'd1);
    reset_n = 0;
    step(1);
    check("mid_reset_x13", xr(13), 32'd0);
    check("mid_reset_x12", xr(12), 32'd0);
    check("mid_reset_busy", busy, 32'd0);
    check("mid_reset_readies", {30'd0, alu_ready, md_ready}, 32'd0);
    reset_n = 1;
    step(1);
    check("after_reset_readies", {30'd0, alu_ready, md_ready}, 32'd3);
    step(2);
    check("skid_discarded_x13", xr(13), 32'd0);

    // After reset the arbitration pointer favours md again.
    drive_alu(5'd20, 32'h200);
    drive_md(5'd21, 32'h210);
    step(1);
    idle_inputs();
    check("rr_reset_md_first", xr(21), 32'h210);
    check("rr_reset_alu_waits", xr(20), 32'd0);
    step(2);
    check("rr_reset_alu_done", xr(20), 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #50000;
    n_bad++;
    $display("FAIL timeout t=%0t got=running want=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
